// File: rtl/mram_feature_packer_pkg.sv
// Shared types and helpers for the MRAM feature packer: FSM states,
// pixels-per-word geometry and the final-lane to byte-enable lookup.
package mram_feature_packer_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);
  localparam int BE_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    DONE
  } state_e;

  // Two nibbles share a byte, so the enable count is ceil((lane+1)/2).
  function automatic logic [BE_W-1:0] be_mask(input logic [LANE_W-1:0] lane);
    case (lane[LANE_W-1:1])
      2'd0:    be_mask = 4'b0001;
      2'd1:    be_mask = 4'b0011;
      2'd2:    be_mask = 4'b0111;
      default: be_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mram_feature_packer_if.sv
// Pixel stream in, MRAM Port A write bus out. The packer takes the slave
// view; the pixel source / memory side takes the master view.
interface mram_feature_packer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int PIX_WIDTH  = 4
);
  logic                  pix_valid;
  logic [PIX_WIDTH-1:0]  pix_data;
  logic                  pix_last;
  logic                  pix_ready;
  logic [ADDR_WIDTH-1:0] MRAM_PORTA_addr;
  logic [DATA_WIDTH-1:0] MRAM_PORTA_wdata;
  logic                  MRAM_PORTA_en;
  logic [3:0]            MRAM_PORTA_we;

  modport slave (
    input  pix_valid, pix_data, pix_last,
    output pix_ready, MRAM_PORTA_addr, MRAM_PORTA_wdata, MRAM_PORTA_en, MRAM_PORTA_we
  );

  modport master (
    output pix_valid, pix_data, pix_last,
    input  pix_ready, MRAM_PORTA_addr, MRAM_PORTA_wdata, MRAM_PORTA_en, MRAM_PORTA_we
  );
endinterface

// File: rtl/mram_feature_packer_lane_reg.sv
// Nibble-insert pack register with lane counter. Presents the word as it
// would look with the current pixel inserted, plus its byte-enable mask.
module mram_pack_lane_reg
  import mram_feature_packer_pkg::*;
#(
  parameter int PIX_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic                  last,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  word_done,
  output logic [DATA_WIDTH-1:0] word,
  output logic [BE_W-1:0]       be
);

  logic [LANE_W-1:0]     lane_q;
  logic [DATA_WIDTH-1:0] pack_q;

  assign word_done = accept && (last || (lane_q == LANE_W'(PIX_PER_WORD - 1)));
  // Upper lanes stay zero because the register clears after every word.
  assign word      = pack_q | (DATA_WIDTH'(pix_data) << (lane_q * PIX_WIDTH));
  assign be        = be_mask(lane_q);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (word_done) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (accept) begin
      lane_q <= lane_q + LANE_W'(1);
      pack_q <= word;
    end
  end

endmodule

// File: rtl/mram_feature_packer.sv
// Packs 4-bit feature pixels into 32-bit MRAM Port A writes with a per-frame
// word budget. Define MRAM_PACK_WORD_COUNT_EN to expose words_written.
module mram_feature_packer
  import mram_feature_packer_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          PIX_WIDTH  = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   max_words,
  mram_feature_packer_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
`ifdef MRAM_PACK_WORD_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   words_written
`endif
);

  state_e                state_q, state_d;
  logic                  pix_ready;
  logic                  accept;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;
  logic [BE_W-1:0]       be;
  logic                  write_ok;

  logic [ADDR_WIDTH:0]   max_words_q;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic                  overflow_q;
  logic                  en_q;
  logic [BE_W-1:0]       we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign accept = bus.pix_valid && pix_ready;

  mram_pack_lane_reg #(
    .PIX_WIDTH  (PIX_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_reg (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .last      (bus.pix_last),
    .pix_data  (bus.pix_data),
    .word_done (word_done),
    .word      (word),
    .be        (be)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (accept && bus.pix_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == FILL);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // word_idx only advances on committed writes, so once the budget is hit
  // every later word in the frame is dropped as well.
  assign write_ok = (word_idx_q != max_words_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      max_words_q <= '0;
      word_idx_q  <= '0;
      overflow_q  <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      en_q <= 1'b0;
      we_q <= '0;
      if (state_q == IDLE && start) begin
        max_words_q <= max_words;
        word_idx_q  <= '0;
        overflow_q  <= 1'b0;
      end
      if (word_done) begin
        if (write_ok) begin
          en_q       <= 1'b1;
          we_q       <= be;
          wdata_q    <= word;
          addr_q     <= ADDR_WIDTH'(BASE_ADDR) + word_idx_q[ADDR_WIDTH-1:0];
          word_idx_q <= word_idx_q + 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.pix_ready        = pix_ready;
  assign bus.MRAM_PORTA_en    = en_q;
  assign bus.MRAM_PORTA_we    = we_q;
  assign bus.MRAM_PORTA_addr  = addr_q;
  assign bus.MRAM_PORTA_wdata = wdata_q;
  assign overflow             = overflow_q;

`ifdef MRAM_PACK_WORD_COUNT_EN
  assign words_written = word_idx_q;
`endif

endmodule

// File: tb/tb_mram_feature_packer.sv
// Self-checking bench: two packers (BASE_ADDR 0 and 1022) share one pixel
// stream; writes are compared against a frame-level reference model.
module tb_mram_feature_packer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   max_words;
  logic          pv, pl;
  logic [3:0]    pd;
  logic          busy0, done0, ovf0, busy1, done1, ovf1;
`ifdef MRAM_PACK_WORD_COUNT_EN
  logic [AW:0]   ww0, ww1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mram_feature_packer_if bus0 ();
  mram_feature_packer_if bus1 ();

  assign bus0.pix_valid = pv;
  assign bus0.pix_data  = pd;
  assign bus0.pix_last  = pl;
  assign bus1.pix_valid = pv;
  assign bus1.pix_data  = pd;
  assign bus1.pix_last  = pl;

  mram_feature_packer #(.BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .max_words(max_words), .bus(bus0),
    .busy(busy0), .done(done0), .overflow(ovf0)
`ifdef MRAM_PACK_WORD_COUNT_EN
    , .words_written(ww0)
`endif
  );

  mram_feature_packer #(.BASE_ADDR(1022)) dut1 (
    .clk(clk), .reset(reset), .start(start), .max_words(max_words), .bus(bus1),
    .busy(busy1), .done(done1), .overflow(ovf1)
`ifdef MRAM_PACK_WORD_COUNT_EN
    , .words_written(ww1)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    we;
  } wr_t;

  wr_t        q0[$];
  wr_t        q1[$];
  logic [3:0] pix[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture every write and confirm byte enables are gated by en.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.MRAM_PORTA_en)
        q0.push_back('{bus0.MRAM_PORTA_addr, bus0.MRAM_PORTA_wdata, bus0.MRAM_PORTA_we});
      if (bus1.MRAM_PORTA_en)
        q1.push_back('{bus1.MRAM_PORTA_addr, bus1.MRAM_PORTA_wdata, bus1.MRAM_PORTA_we});
      check("we_gated", {bus0.MRAM_PORTA_en || bus0.MRAM_PORTA_we == 4'h0,
                         bus1.MRAM_PORTA_en || bus1.MRAM_PORTA_we == 4'h0}, 2'b11);
    end
  end

  // Reference: chop the frame into 8-pixel words, keep the first max_words.
  task automatic model_check(input int which, input int mw, input int base);
    wr_t         got[$];
    int          n, nwords, nexp, c;
    logic [31:0] d;
    if (which == 0) got = q0;
    else            got = q1;
    n      = pix.size();
    nwords = (n + 7) / 8;
    nexp   = (nwords < mw) ? nwords : mw;
    check("model_nwrites", got.size(), nexp);
    for (int w = 0; w < nexp && w < got.size(); w++) begin
      d = 32'h0;
      c = 0;
      for (int i = 0; i < 8; i++) begin
        if (8 * w + i < n) begin
          d = d | (32'(pix[8 * w + i]) << (4 * i));
          c++;
        end
      end
      check("model_addr", got[w].addr, (base + w) % 1024);
      check("model_wdata", got[w].data, d);
      check("model_we", got[w].we, (1 << ((c + 1) / 2)) - 1);
    end
  endtask

  task automatic run_frame(input int n, input int mw, input logic [3:0] p0, input bit rnd);
    int   nwords, nexp;
    logic exp_en;
    pix.delete();
    q0.delete();
    q1.delete();
    for (int i = 0; i < n; i++) pix.push_back(rnd ? 4'($urandom) : 4'(p0 + 4'(i)));
    nwords = (n + 7) / 8;
    nexp   = (nwords < mw) ? nwords : mw;

    start = 1'b1; max_words = (AW+1)'(mw);
    @(posedge clk); #1;
    start = 1'b0; max_words = (AW+1)'($urandom);
    check("fill_busy", {busy0, busy1, bus0.pix_ready}, 3'b111);
    check("ovf_cleared_on_start", {ovf0, ovf1}, 2'b00);

    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(3) == 0) begin
        pv = 1'b0; start = 1'($urandom_range(1));
        @(posedge clk); #1;
        start = 1'b0;
        check("en_idle_gap", {bus0.MRAM_PORTA_en, bus1.MRAM_PORTA_en}, 2'b00);
      end
      pv = 1'b1; pd = pix[i]; pl = (i == n - 1);
      @(posedge clk); #1;
      pv = 1'b0; pl = 1'b0;
      exp_en = ((i % 8 == 7) || (i == n - 1)) && (i / 8 < mw);
      check("en_latency", {bus0.MRAM_PORTA_en, bus1.MRAM_PORTA_en}, {exp_en, exp_en});
    end

    check("flush_state", {busy0, done0, bus0.pix_ready}, 3'b100);
    @(posedge clk); #1;
    check("done_pulse", {done0, done1, busy0, bus0.pix_ready, bus0.MRAM_PORTA_en}, 5'b11100);
    check("ovf_at_done", {ovf0, ovf1}, {nwords > mw, nwords > mw});
    @(posedge clk); #1;
    check("back_to_idle", {done0, busy0, busy1, bus0.pix_ready}, 4'b0000);
`ifdef MRAM_PACK_WORD_COUNT_EN
    check("words_written", {ww0, ww1}, {(AW+1)'(nexp), (AW+1)'(nexp)});
`endif
    model_check(0, mw, 0);
    model_check(1, mw, 1022);
  endtask

  typedef struct {
    int            n;
    logic [3:0]    p0;
    int            mw;
    int            nwr;
    logic          ovf;
    logic [31:0]   w0;
    logic [3:0]    we0;
    logic [31:0]   wl;
    logic [3:0]    wel;
    logic [AW-1:0] al1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16, 4'h1, 4, 2, 1'b0, 32'h87654321, 4'hF, 32'h0FEDCBA9, 4'hF,    10'd1023};
    vecs[1] = '{3,  4'hA, 4, 1, 1'b0, 32'h00000CBA, 4'h3, 32'h00000CBA, 4'h3,    10'd1022};
    vecs[2] = '{16, 4'h1, 1, 1, 1'b1, 32'h87654321, 4'hF, 32'h87654321, 4'hF,    10'd1022};
    vecs[3] = '{24, 4'h0, 4, 3, 1'b0, 32'h76543210, 4'hF, 32'h76543210, 4'hF,    10'd0};
    vecs[4] = '{20, 4'h0, 8, 3, 1'b0, 32'h76543210, 4'hF, 32'h00003210, 4'b0011, 10'd0};
    vecs[5] = '{8,  4'h5, 0, 0, 1'b1, 32'h0,        4'h0, 32'h0,        4'h0,    10'd0};

    reset = 1'b1; start = 1'b0; max_words = '0; pv = 1'b0; pd = '0; pl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy0, done0, ovf0, bus0.pix_ready, bus0.MRAM_PORTA_en,
                            bus0.MRAM_PORTA_we, bus0.MRAM_PORTA_addr, bus0.MRAM_PORTA_wdata}, '0);
    reset = 1'b0;

    // Pixels offered while IDLE are refused and produce no write.
    pv = 1'b1; pd = 4'h5;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_no_accept", {bus0.pix_ready, bus0.MRAM_PORTA_en, busy0}, 3'b000);
    end
    pv = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].n, vecs[v].mw, vecs[v].p0, 1'b0);
      check("vec_nwrites", q0.size(), vecs[v].nwr);
      check("vec_overflow", ovf0, vecs[v].ovf);
      if (vecs[v].nwr > 0 && q0.size() == vecs[v].nwr && q1.size() == vecs[v].nwr) begin
        check("vec_addr0", q0[0].addr, 0);
        check("vec_first", {q0[0].data, q0[0].we}, {vecs[v].w0, vecs[v].we0});
        check("vec_last", {q0[$].data, q0[$].we}, {vecs[v].wl, vecs[v].wel});
        check("vec_last_addr_b1022", q1[$].addr, vecs[v].al1);
      end
    end

    // Reset in the middle of a frame: no write, everything back to zero.
    q0.delete();
    start = 1'b1; max_words = 11'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pv = 1'b1; pd = 4'(i + 9); pl = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midframe_reset_outputs", {busy0, done0, ovf0, bus0.pix_ready, bus0.MRAM_PORTA_en,
                                     bus0.MRAM_PORTA_we, bus0.MRAM_PORTA_addr,
                                     bus0.MRAM_PORTA_wdata}, '0);
    check("midframe_reset_no_write", q0.size(), 0);
    reset = 1'b0; pv = 1'b0;
    @(posedge clk); #1;
    run_frame(8, 4, 4'h3, 1'b0);
    check("post_reset_word", {q0.size() > 0 ? q0[0].data : 32'hDEADBEEF}, 32'hA9876543);

    for (int f = 0; f < 40; f++)
      run_frame(int'($urandom_range(40, 1)), int'($urandom_range(6, 0)), 4'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mram_feature_packer.md
Name: mram_feature_packer

Overview:
- Upstream write stage of the dual-port feature MRAM; sits between the Conv2D engine's pixel output stream and MRAM Port A.
- Accepts one 4-bit feature pixel per cycle and packs 8 pixels into each 32-bit word, lowest lane first.
- Issues byte-enabled Port A writes at an auto-incrementing address; flushes a partial final word on pix_last.
- Reports busy, done and a sticky overflow flag per frame.

Parameters:
- ADDR_WIDTH, 10, MRAM word-address width; must match the MRAM instance.
- DATA_WIDTH, 32, MRAM word width; fixed at 32 because Port A has 4 byte enables.
- PIX_WIDTH, 4, bits per feature pixel; PIX_PER_WORD = DATA_WIDTH/PIX_WIDTH = 8.
- BASE_ADDR, 0, first word address of every frame.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- max_words  in  ADDR_WIDTH+1  word budget for the frame; sampled on start.
- pix_valid  in  1  pixel present.
- pix_data  in  PIX_WIDTH  pixel value.
- pix_last  in  1  last pixel of the frame; qualified by pix_valid.
- pix_ready  out  1  packer accepts a pixel this cycle.
- MRAM_PORTA_addr  out  ADDR_WIDTH  write address.
- MRAM_PORTA_wdata  out  DATA_WIDTH  packed word.
- MRAM_PORTA_en  out  1  write strobe.
- MRAM_PORTA_we  out  4  byte enables.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame completes.
- overflow  out  1  sticky: at least one word was dropped because the budget was exhausted.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all outputs 0; state IDLE; lane counter, pack register and word counter cleared. A reset mid-frame discards any partial word and issues no write.
- States:
  - IDLE: start -> FILL. On entry to FILL, clear overflow and the word counter, latch max_words, load address = BASE_ADDR.
  - FILL: pix_ready=1. Accept a pixel when pix_valid && pix_ready, placing it at bits [4*lane+3 : 4*lane].
  - FILL, 8th pixel (lane 7): register the full word. Next cycle: MRAM_PORTA_en=1, we=4'hF for exactly one cycle. Then lane=0 and address increments.
  - FILL, pix_last at lane k<7: register the partial word with nibbles above k zero-filled; we = low ceil((k+1)/2) bits set (e.g. k=2 -> 4'b0011); go to FLUSH.
  - FILL, pix_last at lane 7: full-word write; go to FLUSH.
  - FLUSH: the final write issues (en high) this cycle; pix_ready=0 -> DONE.
  - DONE: done=1 for one cycle; pix_ready=0 -> IDLE.
- Throughput: 1 pixel/cycle with no stall; Port A never back-pressures.
- Write latency: 1 cycle after the completing pixel. wdata, addr and we are registered and change only with en.
- Address: BASE_ADDR + word_index, modulo 2^ADDR_WIDTH (wraps 1023->0).
- Budget: if word_index == latched max_words when a write would issue, suppress en, set overflow, and keep consuming pixels until pix_last. max_words=0 drops every write.
- busy = (state != IDLE).
- Pixels presented in IDLE/DONE are not accepted (pix_ready=0).
- A start pulse while busy is ignored.
- en is 0 whenever not writing; we is 0 when en is 0.

Optional Feature:
- Macro: MRAM_PACK_WORD_COUNT_EN.
- Defined: adds output words_written [ADDR_WIDTH:0]. It counts committed writes in the current frame, holds after done, and clears on start and on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FILL, FLUSH, DONE);
  - PIX_PER_WORD;
  - byte-enable lookup function lane->we mask.
- Natural sub-module: mram_pack_lane_reg (nibble-insert pack register plus lane counter, emitting word_full/partial mask). The FSM and address/budget logic stay in the top.

Test Plan:
- BASE_ADDR=0, max_words=4, pixels 1..8 then pixels 9..F,0 with last on the 16th -> writes addr0 wdata 0x87654321 we F, addr1 0x0FEDCBA9 we F; done one cycle after the second write.
- 3 pixels A,B,C, last on C -> single write wdata 0x00000CBA, we 4'b0011, addr 0.
- max_words=1, 16 pixels -> only addr0 written; overflow=1 at done; next start clears overflow.
- BASE_ADDR=1022, 24 pixels -> writes at 1022, 1023, 0.
- reset asserted after 5 pixels -> no en pulse, all outputs 0 next cycle; a new 8-pixel frame writes addr BASE_ADDR correctly.
- With MRAM_PACK_WORD_COUNT_EN: 20 pixels, max_words=8 -> words_written=3 after done.
